// File: rtl/picmicro_pkg.sv
// Shared types and constants for the midrange PIC core.
// The ISR entry sequencer imports these.
package picmicro_pkg;

   localparam int          PIC_PC_WIDTH   = 13;
   localparam logic [12:0] PIC_ISR_VECTOR = 13'h0004;

   typedef enum logic [1:0] {
      ISR_IDLE = 2'd0,
      ISR_NOP1 = 2'd1,
      ISR_NOP2 = 2'd2
   } isr_state_t;

endpackage

// File: rtl/picmicro_interrupt_sequencer.sv
// Decides when an interrupt is taken and drives the ISR entry sequence.
// The sequence is two forced NOP slots, a return-PC push, a vector load and a GIE clear.
module picmicro_interrupt_sequencer
   import picmicro_pkg::*;
#(
   parameter int                   PC_WIDTH   = PIC_PC_WIDTH,
   parameter logic [PC_WIDTH-1:0]  ISR_VECTOR = PC_WIDTH'(PIC_ISR_VECTOR)
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                q_end,
   input  logic                next_is_flush,
   input  logic                instr_retfie,
   input  logic                intcon_gie,
   input  logic                intcon_t0ie,
   input  logic                intcon_t0if,
   input  logic                intcon_inte,
   input  logic                intcon_intf,
   input  logic                intcon_rbie,
   input  logic                intcon_rbif,
   input  logic                intcon_peie,
   input  logic                periph_pending,
   output logic                interrupt_flag,
   output logic                isr_force_nop,
   output logic                pc_j_to_isr,
   output logic                pc_push_en,
   output logic [PC_WIDTH-1:0] pc_isr_vector,
   output logic                intcon_gie_clr_en,
   output logic                intcon_gie_set_en,
   output logic                isr_entry_busy
);

   isr_state_t state_q, state_d;
   logic       interrupt_flag_q;
   logic       pending;

   assign pending = (intcon_t0ie & intcon_t0if) |
                    (intcon_inte & intcon_intf) |
                    (intcon_rbie & intcon_rbif) |
                    (intcon_peie & periph_pending);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         interrupt_flag_q <= 1'b0;
         state_q          <= ISR_IDLE;
      end else begin
         interrupt_flag_q <= intcon_gie & pending;
         state_q          <= state_d;
      end
   end

   // A flush slot after a branch is never converted; recognition retries at its q_end.
   always_comb begin
      state_d = state_q;
      if (q_end) begin
         case (state_q)
            ISR_IDLE: if (interrupt_flag_q && !next_is_flush) state_d = ISR_NOP1;
            ISR_NOP1: state_d = ISR_NOP2;
            ISR_NOP2: state_d = ISR_IDLE;
            default:  state_d = ISR_IDLE;
         endcase
      end
   end

   assign interrupt_flag    = interrupt_flag_q;
   assign isr_entry_busy    = (state_q != ISR_IDLE);
   assign isr_force_nop     = (state_q == ISR_NOP1) || (state_q == ISR_NOP2);
   assign pc_j_to_isr       = (state_q == ISR_NOP1);
   assign pc_push_en        = (state_q == ISR_NOP1) && q_end;
   assign intcon_gie_clr_en = (state_q == ISR_NOP1) && q_end;
   assign intcon_gie_set_en = rst_n && instr_retfie && q_end;
   assign pc_isr_vector     = ISR_VECTOR;

endmodule
